// File: rtl/program_loader.sv
// program_loader: host byte loader that writes program bytes into RAM over the shared bus (checksum built under LOADER_CHECKSUM_EN)
module program_loader #(
  parameter int PROG_BYTES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] host_data,
  input  logic       host_strobe,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       n_load_addr,
  output logic       n_load_data,
  output logic       n_ram_write,
  output logic       cpu_hold,
  output logic       byte_ack,
  output logic       done,
  output logic       overrun,
  output logic [3:0] addr,
  output logic [7:0] checksum
);
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, SET_ADDR, SET_DATA, WRITE, NEXT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(PROG_BYTES - 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_d;
  logic edge_det;
  logic go;
  logic [7:0] byte_reg;
  assign edge_det = sync[SYNC_STAGES-1] & ~sync_d;
  assign go = start & (state == IDLE || state == DONE);
  // synchronize the asynchronous host strobe and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], host_strobe};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end
  // session FSM; every output is registered on entry to the state it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_reg    <= 8'h00;
      bus_out     <= 8'h00;
      bus_oe      <= 1'b0;
      n_load_addr <= 1'b1;
      n_load_data <= 1'b1;
      n_ram_write <= 1'b1;
      cpu_hold    <= 1'b0;
      byte_ack    <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      addr        <= 4'h0;
    end else begin
      bus_oe      <= 1'b0;
      n_load_addr <= 1'b1;
      n_load_data <= 1'b1;
      n_ram_write <= 1'b1;
      byte_ack    <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state    <= WAIT_BYTE;
          addr     <= 4'h0;
          done     <= 1'b0;
          overrun  <= 1'b0;
          cpu_hold <= 1'b1;
        end
        WAIT_BYTE: if (edge_det) begin
          byte_reg    <= host_data;
          state       <= SET_ADDR;
          bus_oe      <= 1'b1;
          bus_out     <= {4'h0, addr};
          n_load_addr <= 1'b0;
        end
        SET_ADDR: begin
          state       <= SET_DATA;
          bus_oe      <= 1'b1;
          bus_out     <= byte_reg;
          n_load_data <= 1'b0;
        end
        SET_DATA: begin
          state       <= WRITE;
          n_ram_write <= 1'b0;
        end
        WRITE: begin
          state    <= NEXT;
          byte_ack <= 1'b1;
        end
        NEXT: if (addr == LAST) begin
          state    <= DONE;
          addr     <= 4'h0;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end else begin
          state <= WAIT_BYTE;
          addr  <= addr + 4'd1;
        end
        default: state <= IDLE;
      endcase
      if (edge_det && state != WAIT_BYTE) overrun <= 1'b1;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  // running mod-256 sum, updated as a byte enters NEXT so it lines up with byte_ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum <= 8'h00;
    else if (go) checksum <= 8'h00;
    else if (state == WRITE) checksum <= checksum + byte_reg;
  end
`else
  assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader (16-byte and 4-byte instances share inputs)
module tb_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic host_strobe = 1'b0;
  logic [7:0] bus_out, checksum, q_bus_out, q_checksum;
  logic bus_oe, nla, nld, nrw, cpu_hold, byte_ack, done, overrun;
  logic q_bus_oe, q_nla, q_nld, q_nrw, q_cpu_hold, q_byte_ack, q_done, q_overrun;
  logic [3:0] addr, q_addr, q_last;
  logic [7:0] aq[$];
  logic [7:0] dq[$];
  int wn = 0, acks = 0, multi = 0, oe_bad = 0;
  int compared = 0, mismatched = 0;
  int a0, d0, k0, w0;
  bit ok;

  always #5 clk = ~clk;

  program_loader u16 (
    .clk(clk), .rst(rst), .start(start), .host_data(host_data), .host_strobe(host_strobe),
    .bus_out(bus_out), .bus_oe(bus_oe), .n_load_addr(nla), .n_load_data(nld), .n_ram_write(nrw),
    .cpu_hold(cpu_hold), .byte_ack(byte_ack), .done(done), .overrun(overrun), .addr(addr), .checksum(checksum)
  );

  program_loader #(.PROG_BYTES(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .host_data(host_data), .host_strobe(host_strobe),
    .bus_out(q_bus_out), .bus_oe(q_bus_oe), .n_load_addr(q_nla), .n_load_data(q_nld), .n_ram_write(q_nrw),
    .cpu_hold(q_cpu_hold), .byte_ack(q_byte_ack), .done(q_done), .overrun(q_overrun), .addr(q_addr), .checksum(q_checksum)
  );

  always @(negedge clk) begin
    if (!nla) aq.push_back(bus_out);
    if (!nld) dq.push_back(bus_out);
    if (!nrw) wn++;
    if (byte_ack) acks++;
    if (int'(!nla) + int'(!nld) + int'(!nrw) > 1) multi++;
    if (bus_oe !== (!nla || !nld)) oe_bad++;
    if (!q_nla) q_last = q_bus_out[3:0];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ck(input logic [7:0] v);
`ifdef LOADER_CHECKSUM_EN
    return {24'h0, v};
`else
    return 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    host_strobe = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (byte_ack) break;
      tick(1);
    end
    check(tag, {31'h0, byte_ack}, 32'h1);
  endtask

  task automatic send(input logic [7:0] b);
    host_data = b;
    host_strobe = 1'b1;
    wait_ack("ack_wait");
    host_strobe = 1'b0;
    tick(4);
  endtask

  function automatic bit seq_ok(input int sa, input int sd, input int n, input logic [7:0] first);
    if (aq.size() != sa + n || dq.size() != sd + n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (aq[sa+i] != 8'(i) || dq[sd+i] != first + 8'(i)) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    tick(2);
    check("reset_vec", {4'h0, bus_out, bus_oe, nla, nld, nrw, cpu_hold, byte_ack, done, overrun, addr, checksum},
          {4'h0, 8'h00, 1'b0, 3'b111, 4'b0000, 4'h0, 8'h00});
    rst = 1'b0;
    tick(4);
    // full 16-byte session
    a0 = aq.size(); d0 = dq.size(); k0 = acks; w0 = wn;
    pulse_start();
    check("hold_after_start", {31'h0, cpu_hold}, 32'h1);
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
    check("s16_acks", acks - k0, 16);
    check("s16_writes", wn - w0, 16);
    ok = seq_ok(a0, d0, 16, 8'h10);
    check("s16_bus_seq", {31'h0, ok}, 32'h1);
    check("s16_done", {31'h0, done}, 32'h1);
    check("s16_hold", {31'h0, cpu_hold}, 32'h0);
    check("s16_addr", {28'h0, addr}, 32'h0);
    check("s16_sum", {24'h0, checksum}, ck(8'h78));
    check("s16_overrun", {31'h0, overrun}, 32'h0);
    check("s4_extra_overrun", {31'h0, q_overrun}, 32'h1);
    // 4-byte session with mod-256 wrap
    do_reset();
    pulse_start();
    send(8'hFF);
    send(8'h01);
    check("s4_sum_wrap2", {24'h0, q_checksum}, ck(8'h00));
    send(8'h80);
    check("s4_sum3", {24'h0, q_checksum}, ck(8'h80));
    check("s4_not_done3", {31'h0, q_done}, 32'h0);
    send(8'h80);
    check("s4_done", {31'h0, q_done}, 32'h1);
    check("s4_hold", {31'h0, q_cpu_hold}, 32'h0);
    check("s4_sum", {24'h0, q_checksum}, ck(8'h00));
    check("s4_last_addr", {28'h0, q_last}, 32'h3);
    check("s4_addr", {28'h0, q_addr}, 32'h0);
    check("s16_addr4", {28'h0, addr}, 32'h4);
    check("s16_sum4", {24'h0, checksum}, ck(8'h00));
    // strobe edge landing in SET_DATA is dropped
    do_reset();
    pulse_start();
    a0 = aq.size(); d0 = dq.size(); k0 = acks;
    host_data = 8'h21;
    host_strobe = 1'b1;
    tick(1);
    host_strobe = 1'b0;
    tick(1);
    host_strobe = 1'b1;
    tick(1);
    host_data = 8'hBB;
    tick(4);
    host_strobe = 1'b0;
    tick(6);
    send(8'h22);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    ok = seq_ok(a0, d0, 2, 8'h21);
    check("ovr_bus_seq", {31'h0, ok}, 32'h1);
    check("ovr_acks", acks - k0, 2);
    check("ovr_addr", {28'h0, addr}, 32'h2);
    // asynchronous reset while in WRITE at addr 5
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i));
    host_data = 8'h66;
    host_strobe = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (!nrw) break;
      tick(1);
    end
    check("wr_reached", {31'h0, nrw}, 32'h0);
    check("wr_addr5", {28'h0, addr}, 32'h5);
    rst = 1'b1;
    #1;
    check("arst_vec", {nrw, bus_oe, cpu_hold, done, addr}, {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    host_strobe = 1'b0;
    // start held mid-session, then restart from DONE
    do_reset();
    start = 1'b1;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("held_addr16", {28'h0, addr}, 32'h3);
    check("held_addr4", {28'h0, q_addr}, 32'h3);
    check("held_hold", {31'h0, cpu_hold}, 32'h1);
    start = 1'b0;
    send(8'h04);
    check("rs_done", {31'h0, q_done}, 32'h1);
    check("rs_sum", {24'h0, q_checksum}, ck(8'h0A));
    send(8'h05);
    check("rs_overrun", {31'h0, q_overrun}, 32'h1);
    pulse_start();
    check("rs_clr", {q_done, q_overrun, q_cpu_hold, q_addr}, {1'b0, 1'b0, 1'b1, 4'h0});
    check("rs_clr_sum", {24'h0, q_checksum}, 32'h0);
    check("rs_u16_ignores", {28'h0, addr}, 32'h5);
    send(8'h33);
    check("rs_addr1", {28'h0, q_addr}, 32'h1);
    check("rs_sum_new", {24'h0, q_checksum}, ck(8'h33));
    // sub-cycle glitches and a long-held strobe
    do_reset();
    pulse_start();
    k0 = acks;
    host_strobe = 1'b1; #1 host_strobe = 1'b0; #1 host_strobe = 1'b1; #1 host_strobe = 1'b0;
    tick(1);
    host_data = 8'h77;
    host_strobe = 1'b1; #6 host_strobe = 1'b0;
    tick(15);
    check("glitch_acks", acks - k0, 1);
    k0 = acks;
    host_strobe = 1'b1;
    tick(40);
    host_strobe = 1'b0;
    tick(6);
    check("long_acks", acks - k0, 1);
    check("long_addr", {28'h0, addr}, 32'h2);
    check("one_strobe_low", multi, 0);
    check("oe_consistent", oe_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
